// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
//
// Pixel-colour stage sitting behind the VGA timing counters. It turns the
// pixel address and display enables into a registered 4:4:4 RGB value and
// delays the syncs by the same single stage, so colour and sync stay aligned
// at the pins. Four test patterns are available: a solid background, eight
// vertical colour bars, a box bouncing over the background, and a 32x32
// checkerboard. The pattern select and the box position only change at the
// end of the visible frame, so the picture never tears.
//
// Ports
//   clk        in   pixel clock (also clocks the timing counters)
//   reset      in   synchronous, active-low reset
//   haddr      in   [9:0] horizontal pixel address (valid while xdisplay=1)
//   vaddr      in   [8:0] vertical line address   (valid while ydisplay=1)
//   xdisplay   in   horizontal visible region
//   ydisplay   in   vertical visible region
//   hsync_in   in   horizontal sync from the timing stage
//   vsync_in   in   vertical sync from the timing stage
//   mode       in   [1:0] pattern: 0 solid, 1 bars, 2 box, 3 checker
//   move_en    in   1 = box moves once per frame, 0 = box frozen
//   red        out  [3:0] registered red
//   green      out  [3:0] registered green
//   blue       out  [3:0] registered blue
//   hsync_out  out  hsync_in delayed one clock
//   vsync_out  out  vsync_in delayed one clock
//   frame_tick out  one-clock pulse following the end of the visible frame
// -----------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int          H_ACTIVE = 640,
    parameter int          V_ACTIVE = 480,
    parameter int          BOX_SIZE = 32,
    parameter int          STEP     = 2,
    parameter logic [11:0] BG_RGB   = 12'h271,
    parameter logic [11:0] BOX_RGB  = 12'hF00,
    parameter logic        SYNC_RST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] haddr,
    input  logic [8:0] vaddr,
    input  logic       xdisplay,
    input  logic       ydisplay,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [1:0] mode,
    input  logic       move_en,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       frame_tick
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_BARS    = 2'd1;
    localparam logic [1:0] MODE_BOX     = 2'd2;
    localparam logic [1:0] MODE_CHECKER = 2'd3;

    localparam int NUM_BARS = 8;
    localparam int BAR_W    = H_ACTIVE / NUM_BARS;

    // Box travel limits and step, one bit wider than the position registers
    // so the "about to cross the edge" test can never wrap.
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] X_STEP  = 11'(STEP);
    localparam logic [9:0]  Y_STEP  = 10'(STEP);
    localparam logic [10:0] X_SPAN  = 11'(BOX_SIZE);
    localparam logic [9:0]  Y_SPAN  = 10'(BOX_SIZE);

    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_BLACK = 12'h000;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [11:0] rgb_q,   rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        tick_q,  tick_d;
    logic        ydisp_q, ydisp_d;
    logic [1:0]  mode_q,  mode_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [8:0]  box_y_q, box_y_d;
    // Direction flags: 0 = moving towards larger coordinates, 1 = smaller.
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;

    // -------------------------------------------------------------------------
    // Frame boundary: falling edge of the vertical display enable.
    // -------------------------------------------------------------------------
    logic frame_end;
    logic de;

    assign frame_end = ydisp_q & ~ydisplay;
    assign de        = xdisplay & ydisplay;

    // -------------------------------------------------------------------------
    // Box motion. Each axis bounces between 0 and ACTIVE-BOX_SIZE; when a step
    // would reach or pass an edge the box is clamped onto the edge and the
    // direction flips, so the edge position itself is always displayed once.
    // -------------------------------------------------------------------------
    logic [10:0] x_wide;
    logic [10:0] x_inc;
    logic [10:0] x_dec;
    logic [9:0]  y_wide;
    logic [9:0]  y_inc;
    logic [9:0]  y_dec;

    assign x_wide = {1'b0, box_x_q};
    assign x_inc  = x_wide + X_STEP;
    assign x_dec  = x_wide - X_STEP;
    assign y_wide = {1'b0, box_y_q};
    assign y_inc  = y_wide + Y_STEP;
    assign y_dec  = y_wide - Y_STEP;

    always_comb begin
        box_x_d = box_x_q;
        dir_x_d = dir_x_q;
        box_y_d = box_y_q;
        dir_y_d = dir_y_q;

        if (frame_end && move_en) begin
            // X axis
            if (!dir_x_q) begin
                if (x_inc >= X_MAX) begin
                    box_x_d = X_MAX[9:0];
                    dir_x_d = 1'b1;
                end else begin
                    box_x_d = x_inc[9:0];
                end
            end else begin
                if (x_wide <= X_STEP) begin
                    box_x_d = '0;
                    dir_x_d = 1'b0;
                end else begin
                    box_x_d = x_dec[9:0];
                end
            end

            // Y axis
            if (!dir_y_q) begin
                if (y_inc >= Y_MAX) begin
                    box_y_d = Y_MAX[8:0];
                    dir_y_d = 1'b1;
                end else begin
                    box_y_d = y_inc[8:0];
                end
            end else begin
                if (y_wide <= Y_STEP) begin
                    box_y_d = '0;
                    dir_y_d = 1'b0;
                end else begin
                    box_y_d = y_dec[8:0];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Box hit test, with end coordinates one bit wider than the addresses.
    // -------------------------------------------------------------------------
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic        in_box;

    assign x_end  = x_wide + X_SPAN;
    assign y_end  = y_wide + Y_SPAN;
    assign in_box = (haddr >= box_x_q) && ({1'b0, haddr} < x_end) &&
                    (vaddr >= box_y_q) && ({1'b0, vaddr} < y_end);

    // -------------------------------------------------------------------------
    // Colour bars: one comparator per bar boundary gives a thermometer code,
    // whose population count is the bar index. No divider needed.
    // -------------------------------------------------------------------------
    logic [NUM_BARS-2:0] bar_ge;
    logic [2:0]          bar_idx;
    logic [11:0]         bar_rgb;

    generate
        for (genvar gi = 1; gi < NUM_BARS; gi++) begin : g_bar_edge
            assign bar_ge[gi-1] = (haddr >= 10'(gi * BAR_W));
        end
    endgenerate

    always_comb begin
        bar_idx = '0;
        for (int i = 0; i < NUM_BARS - 1; i++) begin
            bar_idx = bar_idx + {2'b00, bar_ge[i]};
        end
    end

    always_comb begin
        case (bar_idx)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    // -------------------------------------------------------------------------
    // Pattern select and output stage.
    // -------------------------------------------------------------------------
    logic [11:0] pattern_rgb;

    always_comb begin
        case (mode_q)
            MODE_SOLID:   pattern_rgb = BG_RGB;
            MODE_BARS:    pattern_rgb = bar_rgb;
            MODE_BOX:     pattern_rgb = in_box ? BOX_RGB : BG_RGB;
            MODE_CHECKER: pattern_rgb = (haddr[5] ^ vaddr[5]) ? RGB_BLACK : RGB_WHITE;
            default:      pattern_rgb = BG_RGB;
        endcase
    end

    always_comb begin
        rgb_d   = de ? pattern_rgb : 12'h000;
        hsync_d = hsync_in;
        vsync_d = vsync_in;
        tick_d  = frame_end;
        ydisp_d = ydisplay;
        // The pattern select is only picked up between frames.
        mode_d  = frame_end ? mode : mode_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_q   <= '0;
            hsync_q <= SYNC_RST;
            vsync_q <= SYNC_RST;
            tick_q  <= 1'b0;
            ydisp_q <= 1'b0;
            mode_q  <= '0;
            box_x_q <= '0;
            box_y_q <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
            ydisp_q <= ydisp_d;
            mode_q  <= mode_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Drives short "frames" (a handful of visible pixels followed by the falling
// edge of ydisplay) into vga_pattern_gen and compares every output, every
// cycle, with a reference model that works in plain integer pixel
// coordinates. A few directed pixels from the test plan are also checked
// against fixed colours.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

    localparam int H = 640;
    localparam int V = 480;
    localparam int B = 32;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] haddr;
    logic [8:0] vaddr;
    logic       xdisplay;
    logic       ydisplay;
    logic       hsync_in;
    logic       vsync_in;
    logic [1:0] mode;
    logic       move_en;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hsync_out;
    logic       vsync_out;
    logic       frame_tick;

    always #5 clk = ~clk;

    vga_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .haddr      (haddr),
        .vaddr      (vaddr),
        .xdisplay   (xdisplay),
        .ydisplay   (ydisplay),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mode       (mode),
        .move_en    (move_en),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, in plain integers.
    int m_mode;
    int m_bx;
    int m_by;
    int m_dx;
    int m_dy;
    int m_ydisp;
    int max_bx;
    int max_by;

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_colour(input int md, input int x, input int y);
        case (md)
            0:       return 12'h271;
            1:       return bar_tab[x / 80];
            2:       return (x >= m_bx && x < m_bx + B && y >= m_by && y < m_by + B)
                            ? 12'hF00 : 12'h271;
            default: return (((x / 32) + (y / 32)) % 2 == 0) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    // Bounce one axis: reaching or passing an edge parks the box on it and
    // reverses direction.
    task automatic move_axis(input int pos_i, input int dir_i, input int span,
                             output int pos_o, output int dir_o);
        int lim;
        lim   = span - B;
        pos_o = pos_i;
        dir_o = dir_i;
        if (dir_i > 0) begin
            if (pos_i + S >= lim) begin pos_o = lim; dir_o = -1; end
            else                        pos_o = pos_i + S;
        end else begin
            if (pos_i <= S) begin pos_o = 0; dir_o = 1; end
            else                 pos_o = pos_i - S;
        end
    endtask

    // One clock: predict from the currently applied inputs, clock, compare.
    task automatic cycle();
        logic [11:0] e_rgb;
        logic        e_hs;
        logic        e_vs;
        logic        e_tick;
        if (!reset) begin
            e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_tick = 1'b0;
            m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_ydisp = 0;
        end else begin
            e_rgb  = (xdisplay && ydisplay) ? ref_colour(m_mode, haddr, vaddr) : 12'h000;
            e_hs   = hsync_in;
            e_vs   = vsync_in;
            e_tick = (m_ydisp == 1) && !ydisplay;
            if (e_tick) begin
                m_mode = mode;
                if (move_en) begin
                    move_axis(m_bx, m_dx, H, m_bx, m_dx);
                    move_axis(m_by, m_dy, V, m_by, m_dy);
                end
            end
            m_ydisp = ydisplay ? 1 : 0;
            if (m_bx > max_bx) max_bx = m_bx;
            if (m_by > max_by) max_by = m_by;
        end
        @(posedge clk);
        #1;
        check_val("rgb", {red, green, blue}, e_rgb);
        check_val("hsync_out", hsync_out, e_hs);
        check_val("vsync_out", vsync_out, e_vs);
        check_val("frame_tick", frame_tick, e_tick);
    endtask

    task automatic pix(input int x, input int y, input logic xd, input logic yd);
        haddr    = 10'(x);
        vaddr    = 9'(y);
        xdisplay = xd;
        ydisplay = yd;
        hsync_in = 1'($urandom_range(1));
        vsync_in = 1'($urandom_range(1));
        cycle();
    endtask

    task automatic rand_pix(input logic yd);
        pix($urandom_range(H - 1), $urandom_range(V - 1),
            1'($urandom_range(3) != 0), yd);
    endtask

    // Visible pixels around the model's box corners, then the frame end.
    task automatic frame(input int nrand);
        pix(m_bx, m_by, 1'b1, 1'b1);
        pix(m_bx + B - 1, m_by + B - 1, 1'b1, 1'b1);
        if (m_bx > 0)      pix(m_bx - 1, m_by, 1'b1, 1'b1);
        if (m_bx + B < H)  pix(m_bx + B, m_by, 1'b1, 1'b1);
        if (m_by + B < V)  pix(m_bx, m_by + B, 1'b1, 1'b1);
        if (m_by > 0)      pix(m_bx + B - 1, m_by - 1, 1'b1, 1'b1);
        for (int i = 0; i < nrand; i++) rand_pix(1'b1);
        rand_pix(1'b0);
    endtask

    initial begin
        max_bx = 0;
        max_by = 0;
        reset  = 1'b0;
        mode   = 2'd0;
        move_en = 1'b1;

        // Reset held with arbitrary inputs.
        for (int i = 0; i < 3; i++) begin
            mode = 2'($urandom_range(3));
            rand_pix(1'($urandom_range(1)));
        end
        check_val("rst_rgb", {red, green, blue}, 12'h000);
        check_val("rst_sync", {hsync_out, vsync_out}, 2'b11);

        // Release with ydisplay low: no tick until a real 1->0 edge.
        reset = 1'b1;
        mode  = 2'd0;
        rand_pix(1'b0);
        rand_pix(1'b0);
        frame(2);

        // Latency and blanking: visible pixel, then xdisplay drops.
        pix(100, 100, 1'b1, 1'b1);
        check_val("lat_rgb", {red, green, blue}, 12'h271);
        pix(101, 100, 1'b0, 1'b1);
        check_val("blank_rgb", {red, green, blue}, 12'h000);

        // Mode latch: bars requested mid-frame, solid until the frame ends.
        mode = 2'd1;
        pix(85, 10, 1'b1, 1'b1);
        check_val("latch_hold", {red, green, blue}, 12'h271);
        rand_pix(1'b0);
        pix(85, 20, 1'b1, 1'b1);
        check_val("bar_85", {red, green, blue}, 12'hFF0);
        pix(639, 20, 1'b1, 1'b1);
        check_val("bar_639", {red, green, blue}, 12'h000);
        pix(79, 20, 1'b1, 1'b1);
        check_val("bar_79", {red, green, blue}, 12'hFFF);
        for (int k = 0; k < 16; k++) pix(k * 40, 30, 1'b1, 1'b1);
        rand_pix(1'b0);

        // Freeze the box for five frame ends.
        mode    = 2'd2;
        move_en = 1'b0;
        for (int f = 0; f < 5; f++) frame(1);

        // Checkerboard, then a reset in the middle of a line.
        mode = 2'd3;
        frame(1);
        pix(0, 0, 1'b1, 1'b1);
        check_val("chk_0_0", {red, green, blue}, 12'hFFF);
        pix(32, 0, 1'b1, 1'b1);
        check_val("chk_32_0", {red, green, blue}, 12'h000);
        pix(32, 32, 1'b1, 1'b1);
        check_val("chk_32_32", {red, green, blue}, 12'hFFF);
        reset = 1'b0;
        pix(33, 0, 1'b1, 1'b1);
        check_val("midline_rst", {red, green, blue}, 12'h000);
        reset = 1'b1;
        mode  = 2'd1;
        pix(32, 0, 1'b1, 1'b1);
        check_val("mode_after_rst", {red, green, blue}, 12'h271);
        rand_pix(1'b0);

        // Long randomized run: box mode most of the time, occasional freezes,
        // long enough for both axes to hit both edges.
        for (int f = 0; f < 800; f++) begin
            mode    = ($urandom_range(9) < 6) ? 2'd2 : 2'($urandom_range(3));
            move_en = ($urandom_range(9) != 0);
            frame(2);
        end
        check_val("x_peak", max_bx, H - B);
        check_val("y_peak", max_by, V - B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Pixel-colour stage that consumes the horizontal/vertical timing outputs (pixel address, display enables, syncs) and produces registered 4:4:4 RGB plus delay-matched syncs for the VGA pins. It replaces the fixed-colour fill with a selectable test pattern. Patterns: solid background, 8 colour bars, checkerboard, and a box that bounces once per frame over the background. Runs entirely in the pixel clock domain, the same clock that drives the timing counters.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BOX_SIZE, 32, box edge length in pixels (must be < V_ACTIVE)
STEP, 2, box displacement per frame per axis, in pixels
BG_RGB, 12'h271, background colour {r,g,b}
BOX_RGB, 12'hF00, box colour {r,g,b}
SYNC_RST, 1'b1, reset value of hsync_out/vsync_out

Ports:
clk  in  1  pixel clock (same clock as the timing counters)
reset  in  1  synchronous, active-low reset (reset=0 resets on the next clk edge)
haddr  in  10  horizontal pixel address, valid while xdisplay=1
vaddr  in  9  vertical line address, valid while ydisplay=1
xdisplay  in  1  horizontal visible region
ydisplay  in  1  vertical visible region
hsync_in  in  1  horizontal sync from timing stage
vsync_in  in  1  vertical sync from timing stage
mode  in  2  pattern select: 0 solid, 1 bars, 2 box, 3 checker
move_en  in  1  1 = box moves at each frame tick, 0 = box frozen
red  out  4  red output, registered
green  out  4  green output, registered
blue  out  4  blue output, registered
hsync_out  out  1  hsync_in delayed 1 cycle
vsync_out  out  1  vsync_in delayed 1 cycle
frame_tick  out  1  1-cycle pulse at end of visible frame

Behaviour:
- Reset (reset=0 at a clk edge): red/green/blue=0; hsync_out=vsync_out=SYNC_RST; frame_tick=0; ydisp_d=0; mode_q=0; box_x=0, box_y=0; dir_x=dir_y=+. Reset asserted mid-frame takes effect at the next edge, and the box restarts from (0,0).
- Latency: all outputs are 1 cycle after the inputs that produced them. Colours, hsync_out and vsync_out share the same pipeline stage, so alignment is preserved.
- de = xdisplay & ydisplay. When de=0, the next-cycle RGB is 0, regardless of mode.
- Frame tick: ydisp_d is the registered ydisplay. frame_tick is asserted for one cycle when ydisp_d=1 and ydisplay=0 (the falling edge of ydisplay).
- Mode latch: mode_q <= mode only in the cycle frame_tick is generated. A mode change mid-frame never tears the picture.
- Box update, performed in the frame_tick cycle and only if move_en=1. X axis (Y axis identical, using V_ACTIVE):
  - dir +: if box_x+STEP >= H_ACTIVE-BOX_SIZE, then box_x <= H_ACTIVE-BOX_SIZE and dir <= −; else box_x <= box_x+STEP.
  - dir −: if box_x <= STEP, then box_x <= 0 and dir <= +; else box_x <= box_x−STEP.
  - Compute comparisons 1 bit wider than the operands so no wrap-around is possible.
- Box hit: in_box = (haddr >= box_x) & (haddr < box_x+BOX_SIZE) & (vaddr >= box_y) & (vaddr < box_y+BOX_SIZE). Use 11-bit/10-bit sums.
- Pattern, applied when de=1, using mode_q:
  - 0: BG_RGB.
  - 1: bar k = haddr/80 (by comparison chain, no divider). Colours for k=0..7: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - 2: BOX_RGB if in_box, else BG_RGB.
  - 3: FFF if haddr[5]^vaddr[5] = 0, else 000.
- Addresses outside the active range while de=1 are a timing-stage error. The output is don't-care but must not hang the state.

Test Plan:
- Reset: hold reset=0 for 3 clks with arbitrary inputs -> RGB=0, hsync_out=vsync_out=1, box at (0,0); release -> first frame_tick only after ydisplay 1->0.
- Latency/blanking: mode=0, de=1 at cycle n, then xdisplay=0 at n+1 -> RGB=271 at n+1, 000 at n+2; hsync_in pulse at cycle n appears on hsync_out at n+1 only.
- Mode latch: mode_q=0, switch mode to 1 mid-frame -> RGB stays 271 until after the next frame_tick; next frame haddr=85 -> FF0, haddr=639 -> 000, haddr=79 -> FFF.
- Bounce X: move_en=1, run frames -> box_x 0,2,…,606, then 608 with dir −, then 606. At the left edge, box_x=2 -> 0 with dir +. Y axis peaks at 448.
- Freeze: move_en=0 for 5 frame ticks -> box_x/box_y unchanged. Box render with box at (10,20): pixel (10,20) -> F00, (42,20) -> 271, (41,51) -> F00.
- Checker: mode=3 -> (0,0)=FFF, (32,0)=000, (32,32)=FFF; reset=0 mid-line -> RGB=0 next cycle, mode_q back to 0.
